mask_pattern_streamer: RTL and testbench

- Pattern-memory and row-streaming stage that sits directly upstream of the chip's mask-preload deserializer.
- It is driven by the exposure FSM's STREAM window and subscene count.
- Host software loads coded-exposure mask patterns into an on-block two-port memory.
- For each preload window, the block reads the pattern selected by CntSubc row by row and presents one C_MASK_DES_L-bit mask word per CLKMPRE cycle to the serializer/IO.

---
 rtl/mask_pattern_streamer.sv | 154 +++++++++++++++
 tb/tb_mask_pattern_streamer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mask_pattern_streamer.sv
// Pattern memory plus row streamer feeding the mask-preload deserializer.
// Each STREAM window reads one pattern row by row, one mask word per CLKMPRE cycle.
module mask_pattern_streamer #(
    parameter int C_NUM_ROWS     = 160,
    parameter int C_MASK_DES_L   = 18,
    parameter int C_NUM_PATT_MAX = 100,
    parameter int C_ADDR_W       = 15
) (
    input  logic                    CLKMPRE,
    input  logic                    RESET,
    input  logic                    STREAM,
    input  logic [31:0]             CntSubc,
    input  logic [31:0]             Num_Pat,
    input  logic                    PAT_WR_EN,
    input  logic [C_ADDR_W-1:0]     PAT_WR_ADDR,
    input  logic [C_MASK_DES_L-1:0] PAT_WR_DATA,
    input  logic                    ERR_CLR,
    output logic [C_MASK_DES_L-1:0] MASK_DATA,
    output logic                    MASK_VALID,
    output logic [7:0]              MASK_ROW,
    output logic                    MASK_LAST,
    output logic [31:0]             PAT_DONE_CNT,
    output logic                    ROW_ERR,
    output logic                    PAT_ERR,
    output logic                    WR_ERR
);

    localparam int                  DEPTH   = C_NUM_PATT_MAX * C_NUM_ROWS;
    localparam int                  IDX_W   = $clog2(DEPTH);
    localparam logic [C_ADDR_W-1:0] DEPTH_A = C_ADDR_W'(DEPTH);
    localparam logic [8:0]          ROWS    = 9'(C_NUM_ROWS);

    typedef enum logic [1:0] {IDLE, STREAMING, OVERRUN} state_t;

    state_t                    state, state_nxt;
    logic                      stream_d;
    logic [8:0]                row_cnt, row_nxt;
    logic [C_ADDR_W-1:0]       base_q, base_nxt;
    logic                      zero_q, zero_nxt;
    logic                      beat, last_nxt;
    logic [7:0]                beat_row;
    logic                      set_row_err, set_pat_err, wr_oob;
    logic                      pat_ok;
    logic [IDX_W-1:0]          rd_idx, wr_idx;

    logic [C_MASK_DES_L-1:0]   mem [0:DEPTH-1];
    logic [C_MASK_DES_L-1:0]   rd_data_p1;
    logic                      vld_p1, last_p1, zero_p1;
    logic [7:0]                row_p1;
    logic [31:0]               done_cnt;
    logic                      row_err, pat_err, wr_err;

    assign pat_ok = (CntSubc < Num_Pat) && (CntSubc < 32'(C_NUM_PATT_MAX));
    assign wr_oob = PAT_WR_EN && (PAT_WR_ADDR >= DEPTH_A);
    assign wr_idx = IDX_W'(PAT_WR_ADDR);

    // The window-start cycle itself reads row 0, so beats trail STREAM by one cycle.
    always_comb begin
        state_nxt   = state;
        row_nxt     = row_cnt;
        base_nxt    = base_q;
        zero_nxt    = zero_q;
        beat        = 1'b0;
        beat_row    = row_cnt[7:0];
        set_row_err = 1'b0;
        set_pat_err = 1'b0;
        case (state)
            IDLE: begin
                if (STREAM && !stream_d) begin
                    beat        = 1'b1;
                    beat_row    = 8'd0;
                    zero_nxt    = !pat_ok;
                    base_nxt    = pat_ok ? C_ADDR_W'(CntSubc * 32'(C_NUM_ROWS)) : '0;
                    set_pat_err = !pat_ok;
                    row_nxt     = 9'd1;
                    state_nxt   = STREAMING;
                end
            end
            STREAMING: begin
                if (STREAM) begin
                    if (row_cnt < ROWS) begin
                        beat    = 1'b1;
                        row_nxt = row_cnt + 9'd1;
                    end else begin
                        set_row_err = 1'b1;
                        state_nxt   = OVERRUN;
                    end
                end else begin
                    set_row_err = (row_cnt < ROWS);
                    row_nxt     = '0;
                    state_nxt   = IDLE;
                end
            end
            OVERRUN: begin
                if (!STREAM) begin
                    row_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        last_nxt = beat && ({1'b0, beat_row} == ROWS - 9'd1);
        rd_idx   = IDX_W'(base_nxt + C_ADDR_W'(beat_row));
    end

    always_ff @(posedge CLKMPRE) begin
        stream_d <= STREAM;
        if (RESET) begin
            state    <= IDLE;
            row_cnt  <= '0;
            base_q   <= '0;
            zero_q   <= 1'b0;
            vld_p1   <= 1'b0;
            row_p1   <= '0;
            last_p1  <= 1'b0;
            zero_p1  <= 1'b0;
            done_cnt <= '0;
            row_err  <= 1'b0;
            pat_err  <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            row_cnt  <= row_nxt;
            base_q   <= base_nxt;
            zero_q   <= zero_nxt;
            vld_p1   <= beat;
            row_p1   <= beat ? beat_row : '0;
            last_p1  <= last_nxt;
            zero_p1  <= zero_nxt;
            if (last_nxt)
                done_cnt <= done_cnt + 32'd1;
            row_err  <= set_row_err | (row_err & ~ERR_CLR);
            pat_err  <= set_pat_err | (pat_err & ~ERR_CLR);
            wr_err   <= wr_oob      | (wr_err  & ~ERR_CLR);
        end
    end

    // Read-first: a same-cycle write to the address being read streams the old word.
    always_ff @(posedge CLKMPRE) begin
        if (!RESET && PAT_WR_EN && !wr_oob)
            mem[wr_idx] <= PAT_WR_DATA;
        rd_data_p1 <= mem[rd_idx];
    end

    assign MASK_DATA    = (vld_p1 && !zero_p1) ? rd_data_p1 : '0;
    assign MASK_VALID   = vld_p1;
    assign MASK_ROW     = row_p1;
    assign MASK_LAST    = last_p1;
    assign PAT_DONE_CNT = done_cnt;
    assign ROW_ERR      = row_err;
    assign PAT_ERR      = pat_err;
    assign WR_ERR       = wr_err;

endmodule

// File: tb/tb_mask_pattern_streamer.sv
// Bench for mask_pattern_streamer: table of windows, hand sequences and random windows
// checked against a memory/window model of the streamer.
module tb_mask_pattern_streamer;
    localparam int ROWS = 160;
    localparam int W    = 18;
    localparam int PMAX = 100;
    localparam int AW   = 15;

    logic          CLKMPRE = 1'b0;
    logic          RESET, STREAM, PAT_WR_EN, ERR_CLR;
    logic [31:0]   CntSubc, Num_Pat;
    logic [AW-1:0] PAT_WR_ADDR;
    logic [W-1:0]  PAT_WR_DATA;
    logic [W-1:0]  MASK_DATA;
    logic          MASK_VALID, MASK_LAST, ROW_ERR, PAT_ERR, WR_ERR;
    logic [7:0]    MASK_ROW;
    logic [31:0]   PAT_DONE_CNT;

    mask_pattern_streamer #(
        .C_NUM_ROWS(ROWS), .C_MASK_DES_L(W), .C_NUM_PATT_MAX(PMAX), .C_ADDR_W(AW)
    ) dut (
        .CLKMPRE(CLKMPRE), .RESET(RESET), .STREAM(STREAM), .CntSubc(CntSubc),
        .Num_Pat(Num_Pat), .PAT_WR_EN(PAT_WR_EN), .PAT_WR_ADDR(PAT_WR_ADDR),
        .PAT_WR_DATA(PAT_WR_DATA), .ERR_CLR(ERR_CLR), .MASK_DATA(MASK_DATA),
        .MASK_VALID(MASK_VALID), .MASK_ROW(MASK_ROW), .MASK_LAST(MASK_LAST),
        .PAT_DONE_CNT(PAT_DONE_CNT), .ROW_ERR(ROW_ERR), .PAT_ERR(PAT_ERR), .WR_ERR(WR_ERR)
    );

    always #5 CLKMPRE = ~CLKMPRE;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_done = 0;
    logic [W-1:0] mem_m [0:PMAX*ROWS-1];

    logic [W-1:0] q_data[$];
    int           q_row[$];
    logic         q_last[$];

    always @(negedge CLKMPRE) begin
        if (MASK_VALID === 1'b1) begin
            q_data.push_back(MASK_DATA);
            q_row.push_back(int'(MASK_ROW));
            q_last.push_back(MASK_LAST);
        end
    end

    typedef struct {
        int len; int p; int npat; int wr_at; int wr_addr; int wr_data;
        int beats; int row_err; int pat_err; int wr_err;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycle();
        @(negedge CLKMPRE);
    endtask

    task automatic clear_errs();
        ERR_CLR = 1'b1;
        cycle();
        ERR_CLR = 1'b0;
        cycle();
    endtask

    // One STREAM window of len cycles with an optional host write at cycle wr_at.
    task automatic run_window(input string tag, input int len, input int p, input int npat,
                              input int wr_at, input int wr_addr, input int wr_data,
                              input int beats, input int row_err, input int pat_err,
                              input int wr_err);
        bit           valid;
        int           bad;
        int           lasts;
        int           addr;
        logic [W-1:0] ed;
        q_data.delete();
        q_row.delete();
        q_last.delete();
        valid   = (p < npat) && (p < PMAX);
        CntSubc = p;
        Num_Pat = npat;
        for (int i = 0; i < len; i++) begin
            STREAM      = 1'b1;
            PAT_WR_EN   = (i == wr_at);
            PAT_WR_ADDR = AW'(wr_addr);
            PAT_WR_DATA = W'(wr_data);
            cycle();
        end
        STREAM    = 1'b0;
        PAT_WR_EN = 1'b0;
        repeat (3) cycle();

        bad   = 0;
        lasts = 0;
        for (int r = 0; r < q_data.size(); r++) begin
            addr = p * ROWS + r;
            ed   = valid ? mem_m[addr] : '0;
            if (valid && wr_at >= 0 && wr_at < r && wr_addr == addr) ed = W'(wr_data);
            if (q_data[r] !== ed || q_row[r] != r || q_last[r] !== (r == ROWS - 1)) begin
                if (bad == 0)
                    $display("FAIL %s_beat row %0d: got data %h row %0d last %b, expected data %h row %0d last %b",
                             tag, r, q_data[r], q_row[r], q_last[r], ed, r, (r == ROWS - 1));
                bad++;
            end
            if (q_last[r] === 1'b1) lasts++;
        end
        check({tag, "_beats"}, q_data.size(), beats);
        n_chk++;
        if (bad == 0) n_pass++;
        check({tag, "_last_count"}, lasts, (len >= ROWS) ? 1 : 0);
        if (len >= ROWS) exp_done++;
        check({tag, "_done_cnt"}, PAT_DONE_CNT, exp_done);
        check({tag, "_row_err"}, ROW_ERR, row_err);
        check({tag, "_pat_err"}, PAT_ERR, pat_err);
        check({tag, "_wr_err"}, WR_ERR, wr_err);
        if (wr_at >= 0 && wr_at < len && wr_addr < PMAX * ROWS) mem_m[wr_addr] = W'(wr_data);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, MASK_VALID, 0);
        check({tag, "_data"}, MASK_DATA, 0);
        check({tag, "_row"}, MASK_ROW, 0);
        check({tag, "_last"}, MASK_LAST, 0);
        check({tag, "_done"}, PAT_DONE_CNT, 0);
        check({tag, "_errs"}, {ROW_ERR, PAT_ERR, WR_ERR}, 0);
    endtask

    initial begin
        int p, npat, len, wr_at, wr_addr, wr_data, nb;
        RESET = 1'b1; STREAM = 1'b0; PAT_WR_EN = 1'b0; ERR_CLR = 1'b0;
        CntSubc = '0; Num_Pat = '0; PAT_WR_ADDR = '0; PAT_WR_DATA = '0;
        repeat (3) cycle();
        check_idle_outputs("reset");
        RESET = 1'b0;
        cycle();

        // Load patterns 0..4: p0 = row, p1 = ~row, others random.
        for (int a = 0; a < 5 * ROWS; a++) begin
            logic [W-1:0] d;
            if (a < ROWS) d = W'(a);
            else if (a < 2 * ROWS) d = ~W'(a - ROWS);
            else d = W'($urandom);
            mem_m[a]    = d;
            PAT_WR_EN   = 1'b1;
            PAT_WR_ADDR = AW'(a);
            PAT_WR_DATA = d;
            cycle();
        end
        PAT_WR_EN = 1'b0;
        cycle();

        tbl[0] = '{160, 1,   2,   -1, 0,     0,         160, 0, 0, 0};
        tbl[1] = '{160, 5,   2,   -1, 0,     0,         160, 0, 1, 0};
        tbl[2] = '{100, 0,   2,   -1, 0,     0,         100, 1, 0, 0};
        tbl[3] = '{160, 0,   2,   -1, 0,     0,         160, 0, 0, 0};
        tbl[4] = '{165, 1,   2,   -1, 0,     0,         160, 1, 0, 0};
        tbl[5] = '{160, 1,   2,   10, 170,   'h12345,   160, 0, 0, 0};
        tbl[6] = '{160, 1,   2,   -1, 0,     0,         160, 0, 0, 0};
        tbl[7] = '{160, 0,   2,   5,  16000, 'h3FFFF,   160, 0, 0, 1};
        tbl[8] = '{160, 100, 200, -1, 0,     0,         160, 0, 1, 0};
        tbl[9] = '{160, 2,   5,   -1, 0,     0,         160, 0, 0, 0};

        foreach (tbl[k]) begin
            run_window($sformatf("vec%0d", k), tbl[k].len, tbl[k].p, tbl[k].npat,
                       tbl[k].wr_at, tbl[k].wr_addr, tbl[k].wr_data,
                       tbl[k].beats, tbl[k].row_err, tbl[k].pat_err, tbl[k].wr_err);
            clear_errs();
            check($sformatf("vec%0d_errclr", k), {ROW_ERR, PAT_ERR, WR_ERR}, 0);
        end

        // A flag set in the same cycle as ERR_CLR stays set.
        ERR_CLR = 1'b1; PAT_WR_EN = 1'b1; PAT_WR_ADDR = AW'(20000); PAT_WR_DATA = '0;
        cycle();
        ERR_CLR = 1'b0; PAT_WR_EN = 1'b0;
        cycle();
        check("set_beats_clr_wr_err", WR_ERR, 1);
        clear_errs();

        for (int k = 0; k < 12; k++) begin
            p       = $urandom_range(0, 6);
            npat    = $urandom_range(1, 5);
            len     = ($urandom_range(0, 2) == 0) ? $urandom_range(60, 170) : ROWS;
            wr_at   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
            wr_addr = $urandom_range(0, 5 * ROWS - 1);
            wr_data = $urandom & 'h3FFFF;
            nb      = (len < ROWS) ? len : ROWS;
            run_window($sformatf("rnd%0d", k), len, p, npat, wr_at, wr_addr, wr_data, nb,
                       (len != ROWS) ? 1 : 0, (p < npat) ? 0 : 1, 0);
            clear_errs();
        end

        // Reset in the middle of a window, with STREAM still high.
        CntSubc = 1; Num_Pat = 2;
        for (int i = 0; i < 51; i++) begin
            STREAM = 1'b1;
            cycle();
        end
        RESET = 1'b1;
        cycle();
        check_idle_outputs("midrst");
        exp_done = 0;
        RESET  = 1'b0;
        STREAM = 1'b0;
        repeat (3) cycle();
        check("midrst_after_valid", MASK_VALID, 0);
        check("midrst_after_row_err", ROW_ERR, 0);
        run_window("post_reset", ROWS, 1, 2, -1, 0, 0, ROWS, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end
endmodule
